// File: rtl/layer_scheduler_if.sv
// Neuron-side handshake and activation-buffer write bus of the layer scheduler.
// master = scheduler, slave = neuron datapath / activation buffer.
interface layer_scheduler_if #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_LAYERS  = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3
);
  localparam int NI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int LI_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic              neuron_rst;
  logic              neuron_ready;
  logic              neuron_done;
  logic [DATA_W-1:0] neuron_out;
  logic [NI_W-1:0]   neuron_idx;
  logic [LI_W-1:0]   layer_idx;
  logic              in_sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output neuron_rst, neuron_ready, neuron_idx, layer_idx, in_sel,
           wr_en, wr_addr, wr_data,
    input  neuron_done, neuron_out
  );

  modport slave (
    input  neuron_rst, neuron_ready, neuron_idx, layer_idx, in_sel,
           wr_en, wr_addr, wr_data,
    output neuron_done, neuron_out
  );
endinterface

// File: rtl/layer_scheduler.sv
// Steps one shared neuron datapath over every neuron of every layer and stores
// each result in the activation buffer. Optional watchdog: LAYER_SCHED_WATCHDOG_EN.
module layer_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_LAYERS  = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  layer_scheduler_if.master nif
);
  localparam int NI_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int LI_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [NI_W-1:0] LAST_N = NI_W'(NUM_NEURONS - 1);
  localparam logic [LI_W-1:0] LAST_L = LI_W'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_ISSUE, S_WAIT, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t            state_q;
  logic [NI_W-1:0]   neuron_idx_q;
  logic [LI_W-1:0]   layer_idx_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              neuron_rst_q;
  logic              neuron_ready_q;
  logic              wr_en_q;

`ifdef LAYER_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;
`endif

  // Pulse outputs are registered alongside the state so each one is high exactly
  // while the FSM sits in the state that owns it.
  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      neuron_idx_q   <= '0;
      layer_idx_q    <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      neuron_rst_q   <= 1'b0;
      neuron_ready_q <= 1'b0;
      wr_en_q        <= 1'b0;
`ifdef LAYER_SCHED_WATCHDOG_EN
      wd_cnt_q       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      done_q         <= 1'b0;
      neuron_rst_q   <= 1'b0;
      neuron_ready_q <= 1'b0;
      wr_en_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            neuron_idx_q <= '0;
            layer_idx_q  <= '0;
`ifdef LAYER_SCHED_WATCHDOG_EN
            err_q        <= 1'b0;
`endif
            state_q      <= S_RST;
            neuron_rst_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        S_RST: begin
          state_q        <= S_ISSUE;
          neuron_ready_q <= 1'b1;
        end

        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef LAYER_SCHED_WATCHDOG_EN
          wd_cnt_q <= '0;
`endif
        end

        // A completion in the same cycle the watchdog expires still wins.
        S_WAIT: begin
          if (nif.neuron_done) begin
            wr_data_q <= nif.neuron_out;
            state_q   <= S_STORE;
            wr_en_q   <= 1'b1;
          end
`ifdef LAYER_SCHED_WATCHDOG_EN
          else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
`endif
        end

        S_STORE: state_q <= S_NEXT;

        S_NEXT: begin
          if (neuron_idx_q != LAST_N) begin
            neuron_idx_q <= neuron_idx_q + NI_W'(1);
            state_q      <= S_RST;
            neuron_rst_q <= 1'b1;
          end else if (layer_idx_q != LAST_L) begin
            neuron_idx_q <= '0;
            layer_idx_q  <= layer_idx_q + LI_W'(1);
            state_q      <= S_RST;
            neuron_rst_q <= 1'b1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign nif.neuron_rst   = neuron_rst_q;
  assign nif.neuron_ready = neuron_ready_q;
  assign nif.neuron_idx   = neuron_idx_q;
  assign nif.layer_idx    = layer_idx_q;
  assign nif.in_sel       = (layer_idx_q != '0);
  assign nif.wr_en        = wr_en_q;
  assign nif.wr_data      = wr_data_q;
  assign nif.wr_addr      = ADDR_W'(int'(layer_idx_q) * NUM_NEURONS + int'(neuron_idx_q));

`ifdef LAYER_SCHED_WATCHDOG_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Sequences one shared neuron datapath (neuron control FSM plus multiplier, adder and sigmoid) across every neuron of every layer in the DNN core. It starts the neuron for each neuron/layer index and selects that neuron's weight set and input source. It captures each neuron result into the activation buffer, then advances to the next neuron. It sits between the top-level start/done handshake and the neuron control block.

## Interface
- `NUM_NEURONS`, 4, neurons per layer (≥1)
- `NUM_LAYERS`, 2, layers per inference (≥1)
- `DATA_W`, 16, neuron result width
- `ADDR_W`, 3, activation-buffer address width; must be ≥ clog2(NUM_NEURONS*NUM_LAYERS)
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `LAYER_SCHED_WATCHDOG_EN`)

Ports:
- `clk` in 1: single clock; all logic is on the rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: level-sampled; begins an inference when idle
- `busy` out 1: high from the cycle after `start` is accepted through the DONE state
- `done` out 1: one-cycle pulse at inference end
- `err` out 1: watchdog error, sticky until `reset` or next accepted `start`
- `neuron_rst` out 1: reset to the neuron control block
- `neuron_ready` out 1: one-cycle start pulse to the neuron control block
- `neuron_done` in 1: completion pulse from the neuron control block
- `neuron_out` in DATA_W: neuron result, valid while `neuron_done`=1
- `neuron_idx` out clog2(NUM_NEURONS): selects the weight set
- `layer_idx` out clog2(NUM_LAYERS): current layer
- `in_sel` out 1: input source; 0 = external inputs (layer 0), 1 = activation buffer (layers ≥1)
- `wr_en` out 1: activation-buffer write strobe
- `wr_addr` out ADDR_W: equals layer_idx*NUM_NEURONS + neuron_idx
- `wr_data` out DATA_W: registered copy of `neuron_out`

## Operation
- FSM states: IDLE, RST, ISSUE, WAIT, STORE, NEXT, DONE.
- **IDLE**: if `start`=1, clear `neuron_idx`, `layer_idx` and `err`, then go to RST. Otherwise stay.
- **RST**: `neuron_rst`=1 for this one cycle, then go to ISSUE.
- **ISSUE**: `neuron_ready`=1 for this one cycle, then go to WAIT.
- **WAIT**: when `neuron_done`=1, latch `neuron_out` into `wr_data` and go to STORE.
- **STORE**: `wr_en`=1 for one cycle with `wr_addr` and `wr_data` stable, then go to NEXT.
- **NEXT**: indices advance as follows, then go to RST:
  - if `neuron_idx` < NUM_NEURONS-1, increment `neuron_idx`;
  - else if `layer_idx` < NUM_LAYERS-1, clear `neuron_idx` and increment `layer_idx`;
  - else go to DONE instead of RST.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- `in_sel` = (`layer_idx` != 0), combinational.
- `neuron_done` is ignored in every state except WAIT.
- `start` is ignored in every state except IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, all indices 0, `wr_data`=0, `err`=0. Outputs `busy`, `done`, `neuron_rst`, `neuron_ready` and `wr_en` are all 0. `neuron_rst` is 1 only in RST.
- `reset` asserted in any state returns the FSM to IDLE on the next edge. Any in-flight neuron result is discarded and no `wr_en` is issued.
- Per neuron: 1 (RST) + 1 (ISSUE) + W (WAIT cycles, including the cycle `neuron_done` is sampled) + 1 (STORE) + 1 (NEXT) = W+4 cycles.
- Total inference: from the `start`-sampling edge to the `done` pulse is NUM_NEURONS*NUM_LAYERS*(W+4) + 1 cycles.
- `neuron_done` and `reset` in the same cycle: reset wins.
- `start` held high through DONE: a new inference is accepted in the IDLE cycle after DONE.

## Configuration
- `LAYER_SCHED_WATCHDOG_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without `neuron_done`, set `err`=1 and go directly to IDLE. No write and no `done` pulse are issued.
  - `neuron_done` arriving in the same cycle the counter reaches TIMEOUT is accepted normally.
- Not defined: no counter; WAIT waits indefinitely and `err` is tied to 0.

## Test plan
- **Reset values**: assert `reset` 3 cycles -> all outputs at the reset values above; `busy`=0.
- **Full run**: NUM_NEURONS=4, NUM_LAYERS=2, neuron model answers 10 cycles after `neuron_ready` with `neuron_out`=0x0100+k -> 8 writes at addresses 0..7 with data 0x0100..0x0107; `in_sel`=0 for addresses 0..3 and 1 for addresses 4..7; exactly one `done` pulse; cycle count matches the formula.
- **Start while busy**: pulse `start` during WAIT of neuron 2 -> no restart, indices unchanged, single `done`.
- **Spurious done**: assert `neuron_done` during RST, ISSUE and STORE -> no extra writes; sequence unchanged.
- **Reset mid-operation**: assert `reset` in WAIT of layer 1, neuron 1 -> IDLE next cycle, `wr_en` never asserted; a new `start` restarts from address 0.
- **Watchdog** (`LAYER_SCHED_WATCHDOG_EN`, TIMEOUT=16): never assert `neuron_done` -> `err`=1 and IDLE after 16 WAIT cycles, no `done`; next `start` clears `err`.
